// File: rtl/minsec_pkg.sv
// Shared constants and BCD helper for the minutes/seconds stopwatch.
package minsec_pkg;

    localparam int unsigned CNT_W        = 6;
    localparam int unsigned CNT_MAX      = 59;
    localparam int unsigned TICK_DIV_DEF = 25000000;

    // Packs a 0..59 value as {tens, ones} BCD digits.
    function automatic logic [7:0] to_bcd(input logic [CNT_W-1:0] val);
        return {4'(val / CNT_W'(10)), 4'(val % CNT_W'(10))};
    endfunction

endpackage

// File: rtl/min_sec_counter_tick_gen.sv
// Run/pause switch synchronizer plus prescaler producing a one-cycle 1 s tick.
module min_sec_counter_tick_gen #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic tick
);

    localparam int unsigned PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PreLast = PRE_W'(TICK_DIV - 1);

    logic             sw_meta_q;
    logic             run_q;
    logic [PRE_W-1:0] pre_q, pre_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_q <= 1'b0;
            run_q     <= 1'b0;
            pre_q     <= '0;
        end else begin
            sw_meta_q <= sw;
            run_q     <= sw_meta_q;
            pre_q     <= pre_d;
        end
    end

    // Prescaler freezes while paused so the partial second survives a pause.
    always_comb begin
        pre_d = pre_q;
        tick  = 1'b0;
        if (run_q) begin
            if (pre_q == PreLast) begin
                pre_d = '0;
                tick  = 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/min_sec_counter.sv
// Minutes/seconds stopwatch: 1 s tick drives seconds 0..59 carrying into minutes 0..59.
// Define BCD_OUT_EN to add registered packed-BCD copies of both counters.
module min_sec_counter
    import minsec_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEF,
    parameter int unsigned CNT_MAX  = minsec_pkg::CNT_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw,
`ifdef BCD_OUT_EN
    output logic [7:0] s_bcd,
    output logic [7:0] p_bcd,
`endif
    output logic [5:0] s,
    output logic [5:0] p
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(CNT_MAX);

    logic             tick;
    logic [CNT_W-1:0] s_q, s_d;
    logic [CNT_W-1:0] p_q, p_d;

    min_sec_counter_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw),
        .tick  (tick)
    );

    always_comb begin
        s_d = s_q;
        p_d = p_q;
        if (tick) begin
            if (s_q == CntLast) begin
                s_d = '0;
                p_d = (p_q == CntLast) ? '0 : p_q + 1'b1;
            end else begin
                s_d = s_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= '0;
            p_q <= '0;
        end else begin
            s_q <= s_d;
            p_q <= p_d;
        end
    end

    assign s = s_q;
    assign p = p_q;

`ifdef BCD_OUT_EN
    logic [7:0] s_bcd_q, p_bcd_q;

    // Converted from the next-state values so BCD lands on the same edge as binary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_bcd_q <= 8'h00;
            p_bcd_q <= 8'h00;
        end else begin
            s_bcd_q <= to_bcd(s_d);
            p_bcd_q <= to_bcd(p_d);
        end
    end

    assign s_bcd = s_bcd_q;
    assign p_bcd = p_bcd_q;
`endif

endmodule

// File: tb/tb_min_sec_counter.sv
// Directed self-checking bench for min_sec_counter with a short prescaler (TICK_DIV = 4).
module tb_min_sec_counter;

    localparam int unsigned TickDiv = 4;

    logic       clk;
    logic       rst_n;
    logic       sw;
    logic [5:0] s;
    logic [5:0] p;
`ifdef BCD_OUT_EN
    logic [7:0] s_bcd;
    logic [7:0] p_bcd;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned edge_cnt = 0;
    int unsigned max_seen = 0;

    min_sec_counter #(
        .TICK_DIV (TickDiv),
        .CNT_MAX  (59)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw),
`ifdef BCD_OUT_EN
        .s_bcd (s_bcd),
        .p_bcd (p_bcd),
`endif
        .s     (s),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it; tracks the largest output seen.
    task automatic step();
        @(posedge clk);
        #1;
        edge_cnt++;
        if (s > max_seen) max_seen = s;
        if (p > max_seen) max_seen = p;
    endtask

    task automatic run_to(input int unsigned target);
        while (edge_cnt < target) step();
    endtask

    initial begin
        rst_n = 1'b0;
        sw    = 1'b1;

        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("reset_s_%0d", i), s, 0);
            check_eq($sformatf("reset_p_%0d", i), p, 0);
        end
`ifdef BCD_OUT_EN
        check_eq("reset_s_bcd", s_bcd, 8'h00);
        check_eq("reset_p_bcd", p_bcd, 8'h00);
`endif

        // Release between edges; next rising edge is edge 1.
        rst_n    = 1'b1;
        edge_cnt = 0;
        max_seen = 0;

        run_to(5);
        check_eq("first_pre_s", s, 0);
        run_to(6);
        check_eq("first_inc_s", s, 1);
        run_to(9);
        check_eq("second_pre_s", s, 1);
        run_to(10);
        check_eq("second_inc_s", s, 2);

        run_to(2 + 59 * TickDiv);
        check_eq("s59_s", s, 59);
        check_eq("s59_p", p, 0);
        run_to(2 + 60 * TickDiv);
        check_eq("carry_s", s, 0);
        check_eq("carry_p", p, 1);

        run_to(2 + (12 * 60 + 37) * TickDiv);
        check_eq("mid_s", s, 37);
        check_eq("mid_p", p, 12);
`ifdef BCD_OUT_EN
        check_eq("mid_s_bcd", s_bcd, 8'h37);
        check_eq("mid_p_bcd", p_bcd, 8'h12);
`endif

        run_to(2 + 3599 * TickDiv);
        check_eq("top_s", s, 59);
        check_eq("top_p", p, 59);
        run_to(2 + 3600 * TickDiv);
        check_eq("wrap_s", s, 0);
        check_eq("wrap_p", p, 0);
        run_to(2 + 3601 * TickDiv);
        check_eq("after_wrap_s", s, 1);
        check_eq("after_wrap_p", p, 0);
        check_eq("range_max", max_seen, 59);

        // Asynchronous reset in the middle of a clock period.
        run_to(2 + 3603 * TickDiv);
        check_eq("pre_async_s", s, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_s", s, 0);
        check_eq("async_rst_p", p, 0);
        step();
        step();
        rst_n    = 1'b1;
        edge_cnt = 0;

        // Pause: s = 5 at edge 22, prescaler freezes at phase 2 two edges after sw drops.
        run_to(2 + 5 * TickDiv);
        check_eq("pause_start_s", s, 5);
        sw = 1'b0;
        run_to(62);
        check_eq("paused_s", s, 5);
        check_eq("paused_p", p, 0);
        sw = 1'b1;
        run_to(65);
        check_eq("resume_pre_s", s, 5);
        run_to(66);
        check_eq("resume_s", s, 6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
